p4_meta_aligner: RTL
====================

# p4_meta_aligner

Downstream stage of the `vitis_net_p4_0` pipeline instance. Captures the P4 core's unbackpressurable `user_metadata_out` pulses into a small FIFO and re-attaches each entry to the matching packet on the core's `m_axis` stream, emitting it as a per-packet `m_axis_tuser` sideband. With the drop feature compiled in, it also discards packets whose metadata equals a configured drop port. It maintains packet/drop counters and a sticky metadata-overflow flag.

## Interface
- `TDATA_NUM_BYTES`, 64, stream width in bytes (tdata = 8*TDATA_NUM_BYTES bits).
- `USER_META_DATA_WIDTH`, 9, metadata (egress port) width.
- `META_FIFO_DEPTH`, 8, metadata FIFO entries; power of two, ≥2.
- `DROP_PORT`, 9'h1FF, metadata value marking a packet for drop (used only with `P4_META_DROP_EN`).
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `user_metadata_in`  in  USER_META_DATA_WIDTH  metadata from P4 core `user_metadata_out`.
- `user_metadata_in_valid`  in  1  single-cycle metadata strobe; no ready.
- `s_axis_tdata` / `s_axis_tkeep` / `s_axis_tvalid` / `s_axis_tlast`  in  512/64/1/1  packet stream from P4 core `m_axis`.
- `s_axis_tready`  out  1  ready to P4 core.
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tvalid` / `m_axis_tlast`  out  512/64/1/1  aligned output stream.
- `m_axis_tuser`  out  USER_META_DATA_WIDTH  packet metadata, constant for all beats of a packet.
- `m_axis_tready`  in  1  downstream ready.
- `meta_overflow`  out  1  sticky: a metadata strobe was lost because the FIFO was full.
- `pkt_count`  out  32  forwarded packets.
- `drop_count`  out  32  dropped packets (always 0 without the macro).

## Operation
- Meta FIFO: push on `user_metadata_in_valid`. Push is dropped only when full and there is no same-cycle pop; a dropped push sets `meta_overflow`. Pushed data is visible to a pop one cycle after the push.
- Output register: a single stage holding data/keep/last/tuser and `m_axis_tvalid`. `can_load = !m_axis_tvalid || m_axis_tready`.
- FSM states:
  - IDLE (between packets): `s_axis_tready = fifo_nonempty && can_load`. On a beat handshake the FIFO pops and the head is latched into `cur_meta`.
    - Head == DROP_PORT (macro only): beat discarded; go to DROP, or stay in IDLE if `tlast`.
    - Otherwise: beat loaded into the output register with `tuser = head`; go to FWD, or stay in IDLE if `tlast`.
  - FWD: `s_axis_tready = can_load`. Each handshaked beat is loaded with `tuser = cur_meta`. `tlast` returns to IDLE.
  - DROP: `s_axis_tready = 1`. Beats are discarded. `tlast` returns to IDLE.
- A packet never starts without metadata: an empty FIFO holds the stream in IDLE indefinitely.
- `pkt_count` +1 on the input `tlast` handshake of a forwarded packet. `drop_count` +1 on the input `tlast` handshake of a dropped packet. Both wrap modulo 2^32.
- `tkeep` and `tdata` pass unmodified; `tkeep` is not checked.

## Timing
- Latency: input handshake to `m_axis_tvalid` = 1 cycle. Full throughput (1 beat/cycle) while `m_axis_tready` = 1.
- Backpressure: the `m_axis_*` payload holds stable while `m_axis_tvalid && !m_axis_tready`. `s_axis_tready` depends combinationally on `m_axis_tready` (no skid buffer).
- Metadata arriving in the same cycle as the first beat, with an empty FIFO: the beat is accepted on the next cycle.
- Reset (`rst` = 1 at a clock edge):
  - FIFO emptied; state returns to IDLE; output register invalidated.
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser`, `s_axis_tready`, `meta_overflow`, `pkt_count`, `drop_count` all 0.
  - A packet in flight at reset is abandoned. The P4 core must be reset in the same cycle.

## Configuration
- `P4_META_DROP_EN` defined: DROP state and DROP_PORT comparison compiled in; `drop_count` counts.
- Not defined: no DROP state; DROP_PORT packets are forwarded with `tuser` = DROP_PORT; `drop_count` tied to 0.

## Test plan
- Metadata 9'h003, then a 3-beat packet with `m_axis_tready` = 1 -> 3 output beats, `tuser` = 9'h003 on all, `tlast` on beat 3, `pkt_count` = 1, first output 1 cycle after first input beat.
- Packet presented with FIFO empty for 10 cycles, then metadata 9'h005 -> `s_axis_tready` = 0 throughout the wait; packet accepted starting 1 cycle after the strobe; `tuser` = 9'h005.
- Two back-to-back 1-beat packets with metadata 9'h001 and 9'h002, `m_axis_tready` toggling 1/0 -> order and `tuser` preserved; payload stable while stalled; `pkt_count` = 2.
- 9 metadata strobes with no packets (depth 8) -> `meta_overflow` = 1 after the 9th; the next 8 packets carry the first 8 values.
- With `P4_META_DROP_EN`: metadata 9'h1FF then 9'h004, a 4-beat then a 2-beat packet -> first packet absorbed at 1 beat/cycle with no output; second forwarded with `tuser` = 9'h004; `drop_count` = 1, `pkt_count` = 1.
- `rst` asserted mid-FWD with 3 FIFO entries -> next cycle all outputs 0, FIFO empty; new metadata + packet afterwards forwarded normally.

Source files
------------

// File: rtl/p4_meta_aligner.sv
// Re-attaches P4 core metadata strobes to the matching m_axis packet as a per-packet tuser sideband.
// Optional macro P4_META_DROP_EN compiles in discarding of packets whose metadata equals DROP_PORT.
module p4_meta_aligner #(
    parameter int unsigned TDATA_NUM_BYTES = 64,
    parameter int unsigned USER_META_DATA_WIDTH = 9,
    parameter int unsigned META_FIFO_DEPTH = 8,
    parameter logic [USER_META_DATA_WIDTH-1:0] DROP_PORT = 9'h1FF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [USER_META_DATA_WIDTH-1:0] user_metadata_in,
    input  logic                            user_metadata_in_valid,
    input  logic [8*TDATA_NUM_BYTES-1:0]    s_axis_tdata,
    input  logic [TDATA_NUM_BYTES-1:0]      s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [8*TDATA_NUM_BYTES-1:0]    m_axis_tdata,
    output logic [TDATA_NUM_BYTES-1:0]      m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [USER_META_DATA_WIDTH-1:0] m_axis_tuser,
    input  logic                            m_axis_tready,
    output logic                            meta_overflow,
    output logic [31:0]                     pkt_count,
    output logic [31:0]                     drop_count
);
    localparam int unsigned DW = 8 * TDATA_NUM_BYTES;
    localparam int unsigned KW = TDATA_NUM_BYTES;
    localparam int unsigned MW = USER_META_DATA_WIDTH;
    localparam int unsigned AW = $clog2(META_FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1'b1);
`ifdef P4_META_DROP_EN
    localparam logic DROP_EN = 1'b1;
`else
    localparam logic DROP_EN = 1'b0;
`endif

    // ST_DROP is unreachable unless the drop feature is compiled in.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FWD = 2'd1, ST_DROP = 2'd2} state_t;

    state_t          state_r, state_nxt_s;
    logic [MW-1:0]   meta_mem_r [META_FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [AW:0]     count_r;
    logic [MW-1:0]   cur_meta_r, head_s, load_meta_s;
    logic            fifo_nonempty_s, fifo_full_s, can_load_s, drop_hit_s;
    logic            s_ready_s, pop_s, push_s, ovf_set_s, load_s, fwd_last_s, drop_last_s;
    logic            out_valid_r, out_last_r, ovf_r;
    logic [DW-1:0]   out_data_r;
    logic [KW-1:0]   out_keep_r;
    logic [MW-1:0]   out_user_r;
    logic [31:0]     pkt_count_r, drop_count_r;

    // FIFO status and head decode; full means the count MSB is set since depth is a power of two.
    always_comb begin
        fifo_nonempty_s = (count_r != {(AW + 1){1'b0}});
        fifo_full_s     = count_r[AW];
        head_s          = meta_mem_r[rd_ptr_r];
        can_load_s      = !out_valid_r || m_axis_tready;
        drop_hit_s      = DROP_EN && (head_s == DROP_PORT);
        push_s          = user_metadata_in_valid && (!fifo_full_s || pop_s);
        ovf_set_s       = user_metadata_in_valid && fifo_full_s && !pop_s;
    end

    // Packet FSM: next state, input ready, and load/pop/count strobes.
    always_comb begin
        state_nxt_s = state_r;
        s_ready_s   = 1'b0;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        load_meta_s = cur_meta_r;
        fwd_last_s  = 1'b0;
        drop_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                s_ready_s = fifo_nonempty_s && can_load_s;
                if (s_axis_tvalid && s_ready_s) begin
                    pop_s = 1'b1;
                    if (drop_hit_s) begin
                        drop_last_s = s_axis_tlast;
                        state_nxt_s = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        load_s      = 1'b1;
                        load_meta_s = head_s;
                        fwd_last_s  = s_axis_tlast;
                        state_nxt_s = s_axis_tlast ? ST_IDLE : ST_FWD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FWD: begin
                s_ready_s = can_load_s;
                if (s_axis_tvalid && s_ready_s) begin
                    load_s      = 1'b1;
                    fwd_last_s  = s_axis_tlast;
                    state_nxt_s = s_axis_tlast ? ST_IDLE : ST_FWD;
                end else begin
                    state_nxt_s = ST_FWD;
                end
            end
            ST_DROP: begin
                s_ready_s = 1'b1;
                if (s_axis_tvalid) begin
                    drop_last_s = s_axis_tlast;
                    state_nxt_s = s_axis_tlast ? ST_IDLE : ST_DROP;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, FIFO pointers, current packet metadata, and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW + 1){1'b0}};
            cur_meta_r <= {MW{1'b0}};
            ovf_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                cur_meta_r <= head_s;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) ovf_r <= 1'b1;
        end
    end

    // Metadata storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) meta_mem_r[wr_ptr_r] <= user_metadata_in;
    end

    // Single output stage; payload holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            out_keep_r  <= {KW{1'b0}};
            out_user_r  <= {MW{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= s_axis_tlast;
            out_data_r  <= s_axis_tdata;
            out_keep_r  <= s_axis_tkeep;
            out_user_r  <= load_meta_s;
        end else if (m_axis_tready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Packet counters advance on the input tlast handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_r  <= 32'd0;
            drop_count_r <= 32'd0;
        end else begin
            if (fwd_last_s)  pkt_count_r  <= pkt_count_r + 32'd1;
            if (drop_last_s) drop_count_r <= drop_count_r + 32'd1;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tlast  = out_last_r;
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tkeep  = out_keep_r;
    assign m_axis_tuser  = out_user_r;
    assign meta_overflow = ovf_r;
    assign pkt_count     = pkt_count_r;
    assign drop_count    = drop_count_r;
endmodule
